// File: rtl/stream_average_pooling.sv
// Streaming POOLxPOOL average pooling over a raster pixel stream with one row of partial sums.
// Build option: define ROUND_EN for round-half-up results; default truncates (floor).
module stream_average_pooling #(
    parameter int RESOLUTION = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int POOL       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [RESOLUTION-1:0] in_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RESOLUTION-1:0] out_pixel,
    output logic                  out_last
);
    localparam int LOG2P = $clog2(POOL);
    localparam int SUM_W = RESOLUTION + 2 * LOG2P;
    localparam int OUT_W = IMG_W / POOL;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int OC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
`ifdef ROUND_EN
    localparam logic [SUM_W-1:0] ROUND_ADD = SUM_W'(1) << (2 * LOG2P - 1);
`else
    localparam logic [SUM_W-1:0] ROUND_ADD = '0;
`endif

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [SUM_W-1:0]        h_acc_q, h_acc_d;
    logic [SUM_W-1:0]        csum_q [OUT_W];
    logic [SUM_W-1:0]        csum_d [OUT_W];
    logic [RESOLUTION-1:0]   out_pixel_q, out_pixel_d;
    logic                    out_last_q, out_last_d;

    logic                    accept;
    logic                    row_end;
    logic                    win_done;
    logic [COL_W-1:0]        eff_col;
    logic [ROW_W-1:0]        eff_row;
    logic [LOG2P-1:0]        cpos;
    logic [LOG2P-1:0]        rpos;
    logic [OC_W-1:0]         oc;
    logic [SUM_W-1:0]        pix_ext;
    logic [SUM_W-1:0]        row_sum;
    logic [SUM_W-1:0]        win_total;
    logic [SUM_W-1:0]        rounded;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign out_pixel = out_pixel_q;
    assign out_last  = out_last_q;

    always_comb begin
        accept    = in_valid && in_ready;
        // A start-of-frame pixel is placed at the origin no matter where the counters are.
        eff_col   = in_sof ? '0 : col_q;
        eff_row   = in_sof ? '0 : row_q;
        cpos      = eff_col[LOG2P-1:0];
        rpos      = eff_row[LOG2P-1:0];
        oc        = OC_W'(eff_col >> LOG2P);
        pix_ext   = SUM_W'(in_pixel);
        row_sum   = h_acc_q + pix_ext;
        win_total = csum_q[oc] + row_sum;
        rounded   = win_total + ROUND_ADD;
        row_end   = (cpos == LOG2P'(POOL - 1));
        win_done  = accept && row_end && (rpos == LOG2P'(POOL - 1));

        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        h_acc_d     = h_acc_q;
        csum_d      = csum_q;
        out_pixel_d = out_pixel_q;
        out_last_d  = out_last_q;

        if (accept) begin
            h_acc_d = (cpos == '0) ? pix_ext : row_sum;
            if (row_end) begin
                csum_d[oc] = (rpos == '0) ? row_sum : (csum_q[oc] + row_sum);
            end
            if (eff_col == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (eff_row == ROW_W'(IMG_H - 1)) ? '0 : (eff_row + ROW_W'(1));
            end else begin
                col_d = eff_col + COL_W'(1);
                row_d = eff_row;
            end
        end

        if (win_done) begin
            out_pixel_d = RESOLUTION'(rounded >> (2 * LOG2P));
            out_last_d  = (eff_row == ROW_W'(IMG_H - 1)) && (eff_col == COL_W'(IMG_W - 1));
        end

        case (state_q)
            ACCUM: if (win_done) state_d = HOLD;
            HOLD:  if (out_ready && !win_done) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            col_q       <= '0;
            row_q       <= '0;
            h_acc_q     <= '0;
            out_pixel_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            h_acc_q     <= h_acc_d;
            out_pixel_q <= out_pixel_d;
            out_last_q  <= out_last_d;
        end
    end

    // Column sums need no reset: every entry is overwritten on the first row of each window band.
    always_ff @(posedge clk) begin
        csum_q <= csum_d;
    end
endmodule

// File: tb/tb_stream_average_pooling.sv
// Bench for stream_average_pooling: 4x4 instance for directed/random frames, 28x28 instance for the full-size case.
module tb_stream_average_pooling;
    localparam int RES  = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int P    = 2;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           in_valid, in_ready, in_sof, out_valid, out_ready, out_last;
    logic [RES-1:0] in_pixel, out_pixel;
    logic           in_valid28, in_ready28, in_sof28, out_valid28, out_ready28, out_last28;
    logic [RES-1:0] in_pixel28, out_pixel28;

    stream_average_pooling #(.RESOLUTION(RES), .IMG_W(W), .IMG_H(H), .POOL(P)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_last(out_last));

    stream_average_pooling u_dut28 (
        .clk(clk), .reset(reset), .in_valid(in_valid28), .in_ready(in_ready28), .in_sof(in_sof28),
        .in_pixel(in_pixel28), .out_valid(out_valid28), .out_ready(out_ready28),
        .out_pixel(out_pixel28), .out_last(out_last28));

    int n_cmp  = 0;
    int n_fail = 0;
    int out_count = 0;
    int last_seen = 0;
    int out_cnt28 = 0;
    int last28_cnt = 0;
    bit rand_ready = 1'b0;
    logic [RES:0] exp_q[$];
    logic [RES:0] mon_exp;

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, got, req, $time);
        end
    endtask

    // Reference model: keep the current frame in an array, average each window once its last pixel lands.
    int mem[NPIX];
    int mpos = 0;

    function automatic void model_push(input int p, input bit sof);
        int r, c, sum, res;
        if (sof) mpos = 0;
        r = mpos / W;
        c = mpos % W;
        mem[mpos] = p;
        if ((r % P == P - 1) && (c % P == P - 1)) begin
            sum = 0;
            for (int dr = 0; dr < P; dr++)
                for (int dc = 0; dc < P; dc++)
                    sum += mem[(r - dr) * W + (c - dc)];
`ifdef ROUND_EN
            res = (sum + (P * P) / 2) / (P * P);
`else
            res = sum / (P * P);
`endif
            exp_q.push_back({(mpos == NPIX - 1), RES'(res)});
        end
        mpos = (mpos + 1) % NPIX;
    endfunction

    // Scoreboard for the 4x4 instance.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            out_count++;
            if (out_last) last_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", int'(out_pixel), -1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_pixel", int'(out_pixel), int'(mon_exp[RES-1:0]));
                check("out_last", int'(out_last), int'(mon_exp[RES]));
            end
        end
    end

    // Checker for the 28x28 instance.
    always @(negedge clk) begin
        if (!reset && out_valid28 === 1'b1 && out_ready28 === 1'b1) begin
            out_cnt28++;
            check("pool28_pixel", int'(out_pixel28), 255);
            if (out_last28) begin
                last28_cnt++;
                check("pool28_last_pos", out_cnt28, 196);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the pixel transferred.
    task automatic send_pixel(input int p, input bit sof);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_pixel = RES'(p);
        in_sof   = sof;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [RES-1:0] pix [NPIX];
        logic [RES-1:0] exp_px [4];
    } vec_t;

    vec_t vecs[4];
    int   base;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; out_ready = 1'b1;
        in_valid28 = 1'b0; in_sof28 = 1'b0; in_pixel28 = '0; out_ready28 = 1'b1;

        for (int i = 0; i < NPIX; i++) begin
            vecs[0].pix[i] = RES'(i);
            vecs[1].pix[i] = 8'd255;
            vecs[3].pix[i] = (i % 2 == 1) ? 8'd255 : 8'd0;
        end
        vecs[2].pix = '{8'd1, 8'd0, 8'd255, 8'd254, 8'd0, 8'd0, 8'd1, 8'd0,
                        8'd7, 8'd7, 8'd100, 8'd200, 8'd7, 8'd8, 8'd50, 8'd51};
`ifdef ROUND_EN
        vecs[0].exp_px = '{8'd3, 8'd5, 8'd11, 8'd13};
        vecs[2].exp_px = '{8'd0, 8'd128, 8'd7, 8'd100};
        vecs[3].exp_px = '{8'd128, 8'd128, 8'd128, 8'd128};
`else
        vecs[0].exp_px = '{8'd2, 8'd4, 8'd10, 8'd12};
        vecs[2].exp_px = '{8'd0, 8'd127, 8'd7, 8'd100};
        vecs[3].exp_px = '{8'd127, 8'd127, 8'd127, 8'd127};
`endif
        vecs[1].exp_px = '{8'd255, 8'd255, 8'd255, 8'd255};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst28_out_valid", int'(out_valid28), 0);
        @(posedge clk);
        #1;

        // Table-driven frames, full throughput.
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), vecs[v].exp_px[k]});
            for (int i = 0; i < NPIX; i++) send_pixel(int'(vecs[v].pix[i]), (i == 0));
            drain();
        end

        // Backpressure: hold the first result while downstream stalls.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            model_push(i, (i == 0));
            send_pixel(i, (i == 0));
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_pixel", int'(out_pixel), int'(exp_q[0][RES-1:0]));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        model_push(6, 1'b0);
        in_valid = 1'b1; in_pixel = 8'd6; in_sof = 1'b0;
        #1;
        check("bp_resume_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 7; i < NPIX; i++) begin
            model_push(i, 1'b0);
            send_pixel(i, 1'b0);
        end
        drain();

        // Resync with in_sof mid-frame.
        for (int i = 0; i < 7; i++) begin
            model_push(200, (i == 0));
            send_pixel(200, (i == 0));
        end
        drain();
        base = out_count;
        for (int i = 0; i < NPIX; i++) begin
            model_push(i, (i == 0));
            send_pixel(i, (i == 0));
        end
        drain();
        check("sof_resync_outputs", out_count - base, 4);

        // Reset mid-frame, on the presentation of pixel 9.
        for (int i = 0; i < 9; i++) begin
            model_push(50 + i, (i == 0));
            send_pixel(50 + i, (i == 0));
        end
        drain();
        reset = 1'b1;
        in_valid = 1'b1; in_pixel = 8'd59; in_sof = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        mpos = 0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        base = out_count;
        for (int i = 0; i < NPIX; i++) begin
            model_push(i, 1'b0);
            send_pixel(i, 1'b0);
        end
        drain();
        check("rst_resync_outputs", out_count - base, 4);

        // Random traffic over three back-to-back frames, in_sof only on the very first pixel.
        last_seen = 0;
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                int p;
                int gap;
                p = int'($urandom_range(0, 255));
                gap = int'($urandom_range(0, 2));
                model_push(p, (f == 0 && i == 0));
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                end
                send_pixel(p, (f == 0 && i == 0));
            end
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check("random_last_count", last_seen, 3);

        // Full-size 28x28 frame of 255s.
        for (int i = 0; i < 28 * 28; i++) begin
            in_valid28 = 1'b1;
            in_pixel28 = 8'd255;
            in_sof28   = (i == 0);
            @(negedge clk);
            if (!in_ready28) check("pool28_in_ready", int'(in_ready28), 1);
            @(posedge clk);
            #1;
        end
        in_valid28 = 1'b0;
        in_sof28 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pool28_out_count", out_cnt28, 196);
        check("pool28_last_count", last28_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
